// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor: watches CHANNELS serial HDLC lines in parallel. Each channel
// finds flags, aborts and idle, drops stuffed zeros, delimits frames and sorts them
// into good or errored. Each channel keeps four saturating counters, and a
// registered select/readback port with a per-channel clear gives access to them.
module hdlc_line_monitor #(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 16,
  parameter int MIN_BYTES = 4,
  parameter int MAX_BYTES = 128,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [CHANNELS-1:0]   Line,
  input  logic [CHANNELS-1:0]   LineEn,
  output logic [CHANNELS-1:0]   FlagDet,
  output logic [CHANNELS-1:0]   AbortDet,
  output logic [CHANNELS-1:0]   FrameOk,
  output logic [CHANNELS-1:0]   FrameErr,
  output logic [CHANNELS-1:0]   InFrame,
  output logic [CHANNELS-1:0]   Idle,
  output logic [CHANNELS*8-1:0] FrameBytes,
  input  logic [CH_W-1:0]       RdChan,
  input  logic [1:0]            RdSel,
  output logic [CNT_W-1:0]      RdData,
  input  logic                  Clr
);

  // The destuffed bit count saturates one byte past the largest legal frame.
  // Any saturated count is therefore still classified as oversize.
  localparam int                BITS_MAX  = MAX_BYTES * 8 + 8;
  localparam int                BITS_W    = $clog2(BITS_MAX + 1);
  localparam logic [BITS_W-1:0] BITS_SAT  = BITS_W'(BITS_MAX);
  localparam logic [7:0]        FLAG_PAT  = 8'h7E;
  localparam logic [7:0]        ABORT_PAT = 8'h7F;

  typedef enum logic {S_HUNT = 1'b0, S_OPEN = 1'b1} state_t;

  logic             rd_valid;
  logic [CNT_W-1:0] cnt_next [CHANNELS][4];
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  assign rd_valid = (int'(RdChan) < CHANNELS);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t            state_q, state_d;
    // Only the seven most recent raw bits are stored. The eighth bit of the
    // window is the bit arriving on the current edge.
    logic [6:0]        sh_q, sh_d;
    logic [7:0]        win;
    logic [3:0]        run_q, run_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              flag_q, flag_d, abort_q, abort_d;
    logic              ok_q, ok_d, err_q, err_d;
    logic [7:0]        fb_q, fb_d;
    logic [3:0]        inc;
    logic              clr;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    int                payload;

    // Bit-level detection, destuffed bit counting, HUNT/OPEN transitions and frame classification.
    always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      run_d   = run_q;
      bits_d  = bits_q;
      flag_d  = 1'b0;
      abort_d = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      fb_d    = fb_q;
      inc     = 4'b0000;
      win     = {sh_q, Line[gi]};
      // At the flag's final 0, the count already holds the flag's leading 0 and its six 1s.
      payload = int'(bits_q) - 7;
      if (LineEn[gi]) begin
        sh_d = win[6:0];
        if (Line[gi]) begin
          run_d = (run_q == 4'd15) ? run_q : run_q + 4'd1;
        end else begin
          run_d = 4'd0;
        end
        // A 0 that follows exactly five 1s was inserted by the transmitter, so it is not counted.
        if (Line[gi] || run_q != 4'd5) begin
          bits_d = (bits_q == BITS_SAT) ? bits_q : bits_q + BITS_W'(1);
        end
        if (win == FLAG_PAT) begin
          flag_d  = 1'b1;
          inc[3]  = 1'b1;
          bits_d  = '0;
          state_d = S_OPEN;
          // A payload of zero or less means back-to-back or shared flags, which are not frames.
          if (state_q == S_OPEN && payload > 0) begin
            if ((payload % 8) != 0 || payload < MIN_BYTES * 8 || payload > MAX_BYTES * 8) begin
              err_d  = 1'b1;
              inc[1] = 1'b1;
            end else begin
              ok_d   = 1'b1;
              inc[0] = 1'b1;
              fb_d   = 8'(payload / 8);
            end
          end
        end else if (win == ABORT_PAT) begin
          abort_d = 1'b1;
          if (state_q == S_OPEN) begin
            inc[2]  = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
    end

    // Frame state register.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        state_q <= S_HUNT;
      end else begin
        state_q <= state_d;
      end
    end

    // Line tracking registers and the registered detection pulses.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        sh_q    <= 7'h7F;
        run_q   <= 4'd0;
        bits_q  <= '0;
        flag_q  <= 1'b0;
        abort_q <= 1'b0;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
        fb_q    <= 8'd0;
      end else begin
        sh_q    <= sh_d;
        run_q   <= run_d;
        bits_q  <= bits_d;
        flag_q  <= flag_d;
        abort_q <= abort_d;
        ok_q    <= ok_d;
        err_q   <= err_d;
        fb_q    <= fb_d;
      end
    end

    assign clr = Clr && rd_valid && (int'(RdChan) == gi);

    // Saturating statistics. Order is good, err, abort, flag. A clear on the same edge overrides any increment.
    always_comb begin
      for (int k = 0; k < 4; k++) begin
        cnt_d[k] = cnt_q[k];
        if (clr) begin
          cnt_d[k] = '0;
        end else if (inc[k] && cnt_q[k] != '1) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end

    // Statistics registers.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else begin
        for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      end
    end

    for (genvar gk = 0; gk < 4; gk++) begin : g_cnt
      assign cnt_next[gi][gk] = cnt_d[gk];
    end

    assign FlagDet[gi]           = flag_q;
    assign AbortDet[gi]          = abort_q;
    assign FrameOk[gi]           = ok_q;
    assign FrameErr[gi]          = err_q;
    assign InFrame[gi]           = (state_q == S_OPEN);
    assign Idle[gi]              = (run_q >= 4'd8);
    assign FrameBytes[gi*8 +: 8] = fb_q;
  end

  // The readback mux uses the counters after this edge's update or clear.
  // An out-of-range channel reads as zero.
  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(RdChan) == c) rd_data_d = cnt_next[c][RdSel];
    end
  end

  // Readback data register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign RdData = rd_data_q;

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb_hdlc_line_monitor: directed scenarios followed by randomized multi-channel
// HDLC traffic. Each cycle the outputs are compared against a behavioural
// line model.
module tb_hdlc_line_monitor;
  localparam int CH    = 3;
  localparam int CNT_W = 6;
  localparam int MIN_B = 4;
  localparam int MAX_B = 128;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int LIMIT = 4000;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [CH-1:0]   Line = '0;
  logic [CH-1:0]   LineEn = '0;
  logic [CH-1:0]   FlagDet, AbortDet, FrameOk, FrameErr, InFrame, Idle;
  logic [CH*8-1:0] FrameBytes;
  logic [1:0]      RdChan = 2'd0;
  logic [1:0]      RdSel = 2'd0;
  logic [CNT_W-1:0] RdData;
  logic            Clr = 1'b0;

  always #5 Clk = ~Clk;

  hdlc_line_monitor #(
    .CHANNELS (CH),
    .CNT_W    (CNT_W),
    .MIN_BYTES(MIN_B),
    .MAX_BYTES(MAX_B)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Line      (Line),
    .LineEn    (LineEn),
    .FlagDet   (FlagDet),
    .AbortDet  (AbortDet),
    .FrameOk   (FrameOk),
    .FrameErr  (FrameErr),
    .InFrame   (InFrame),
    .Idle      (Idle),
    .FrameBytes(FrameBytes),
    .RdChan    (RdChan),
    .RdSel     (RdSel),
    .RdData    (RdData),
    .Clr       (Clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state. It holds the last 8 raw bits, the current run of raw 1s,
  // the destuffed bits since the last flag, and whether a frame is open.
  int m_hist [CH];
  int m_ones [CH];
  int m_bits [CH];
  bit m_open [CH];
  bit e_flag [CH];
  bit e_abort[CH];
  bit e_ok   [CH];
  bit e_err  [CH];
  int e_fb   [CH];
  int m_cnt  [CH][4];
  int e_rd;
  int en_pct [CH];

  // Transmit side: raw line bits waiting per channel, plus the stuffer's ones run.
  bit txq   [CH][$];
  int g_ones[CH];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic bump(input int c, input int k);
    if (m_cnt[c][k] < CMAX) m_cnt[c][k]++;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_hist[c] = 8'hFF; m_ones[c] = 0; m_bits[c] = 0; m_open[c] = 1'b0;
      e_flag[c] = 1'b0; e_abort[c] = 1'b0; e_ok[c] = 1'b0; e_err[c] = 1'b0; e_fb[c] = 0;
      for (int k = 0; k < 4; k++) m_cnt[c][k] = 0;
      txq[c].delete();
      g_ones[c] = 0;
    end
    e_rd = 0;
  endtask

  task automatic model_bit(input int c, input bit b);
    bit stuffed;
    int payload;
    stuffed = (b == 1'b0) && (m_ones[c] == 5);
    payload = m_bits[c] - 7;
    m_hist[c] = ((m_hist[c] << 1) | int'(b)) & 255;
    m_ones[c] = b ? m_ones[c] + 1 : 0;
    if (!stuffed) m_bits[c]++;
    if (m_hist[c] == 8'h7E) begin
      e_flag[c] = 1'b1;
      bump(c, 3);
      if (m_open[c] && payload > 0) begin
        if (payload % 8 != 0 || payload < MIN_B * 8 || payload > MAX_B * 8) begin
          e_err[c] = 1'b1;
          bump(c, 1);
          $display("ch%0d errored frame, %0d payload bits (t=%0t)", c, payload, $time);
        end else begin
          e_ok[c] = 1'b1;
          e_fb[c] = payload / 8;
          bump(c, 0);
          $display("ch%0d good frame, %0d bytes (t=%0t)", c, payload / 8, $time);
        end
      end
      m_open[c] = 1'b1;
      m_bits[c] = 0;
    end else if (m_hist[c] == 8'h7F) begin
      e_abort[c] = 1'b1;
      if (m_open[c]) begin
        bump(c, 2);
        m_open[c] = 1'b0;
        $display("ch%0d in-frame abort (t=%0t)", c, $time);
      end
    end
  endtask

  task automatic push_data_bit(input int c, input bit b);
    txq[c].push_back(b);
    g_ones[c] = b ? g_ones[c] + 1 : 0;
    if (g_ones[c] == 5) begin
      txq[c].push_back(1'b0);
      g_ones[c] = 0;
    end
  endtask

  task automatic push_byte(input int c, input logic [7:0] v);
    for (int i = 0; i < 8; i++) push_data_bit(c, v[i]);
  endtask

  task automatic push_raw(input int c, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) txq[c].push_back(v[i]);
    g_ones[c] = 0;
  endtask

  task automatic push_ones(input int c, input int n);
    for (int i = 0; i < n; i++) txq[c].push_back(1'b1);
    g_ones[c] = 0;
  endtask

  task automatic push_flag(input int c);
    push_raw(c, 8'h7E);
  endtask

  task automatic gen_random(input int c);
    int k, n;
    k = $urandom_range(0, 19);
    if (k == 19) begin
      push_ones(c, $urandom_range(8, 16));
    end else if (k >= 17) begin
      push_flag(c);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) push_byte(c, 8'($urandom));
      push_raw(c, 8'h7F);
      push_ones(c, $urandom_range(0, 10));
    end else begin
      push_flag(c);
      if (k == 16) begin
        n = MAX_B + $urandom_range(0, 2);
        for (int i = 0; i < n; i++) push_byte(c, 8'($urandom));
      end else if (k >= 14) begin
        n = $urandom_range(1, 100);
        if (n % 8 == 0) n++;
        for (int i = 0; i < n; i++) push_data_bit(c, 1'($urandom));
      end else if (k >= 12) begin
        n = $urandom_range(0, MIN_B - 1);
        for (int i = 0; i < n; i++) push_byte(c, 8'($urandom));
      end else begin
        n = (k == 0) ? MIN_B : $urandom_range(MIN_B, 24);
        for (int i = 0; i < n; i++) push_byte(c, 8'($urandom));
      end
      push_flag(c);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("flag_det[%0d]", c), FlagDet[c], e_flag[c]);
      chk($sformatf("abort_det[%0d]", c), AbortDet[c], e_abort[c]);
      chk($sformatf("frame_ok[%0d]", c), FrameOk[c], e_ok[c]);
      chk($sformatf("frame_err[%0d]", c), FrameErr[c], e_err[c]);
      chk($sformatf("in_frame[%0d]", c), InFrame[c], m_open[c]);
      chk($sformatf("idle[%0d]", c), Idle[c], (m_ones[c] >= 8) ? 1 : 0);
      chk($sformatf("frame_bytes[%0d]", c), FrameBytes[c*8 +: 8], e_fb[c]);
    end
    chk("rd_data", RdData, e_rd);
  endtask

  // Called just after a falling edge. It drives one cycle of inputs, advances
  // the model past the next rising edge, then checks at the following falling edge.
  task automatic run_cycle(input bit allow);
    bit b;
    for (int c = 0; c < CH; c++) begin
      e_flag[c] = 1'b0; e_abort[c] = 1'b0; e_ok[c] = 1'b0; e_err[c] = 1'b0;
    end
    for (int c = 0; c < CH; c++) begin
      if (allow && txq[c].size() > 0 && $urandom_range(0, 99) < en_pct[c]) begin
        b = txq[c].pop_front();
        LineEn[c] = 1'b1;
        Line[c]   = b;
        model_bit(c, b);
      end else begin
        LineEn[c] = 1'b0;
        Line[c]   = 1'($urandom_range(0, 1));
      end
    end
    if (Clr && int'(RdChan) < CH) begin
      for (int k = 0; k < 4; k++) m_cnt[int'(RdChan)][k] = 0;
    end
    e_rd = (int'(RdChan) < CH) ? m_cnt[int'(RdChan)][int'(RdSel)] : 0;
    @(negedge Clk);
    compare_all();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((txq[0].size() + txq[1].size() + txq[2].size()) > 0 && guard < LIMIT) begin
      run_cycle(1'b1);
      guard++;
    end
    if (guard >= LIMIT) chk("drain_timeout", guard, 0);
  endtask

  task automatic read_cnt(input int c, input int sel, output int v);
    RdChan = 2'(c);
    RdSel  = 2'(sel);
    Clr    = 1'b0;
    run_cycle(1'b0);
    v = int'(RdData);
  endtask

  task automatic reset_now();
    LineEn = '0;
    Clr    = 1'b0;
    Rst    = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_in_frame", InFrame, 0);
    chk("rst_frame_bytes", FrameBytes, 0);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    int v, guard;
    model_reset();
    for (int c = 0; c < CH; c++) en_pct[c] = 100;
    repeat (2) @(negedge Clk);
    compare_all();
    Rst = 1'b0;

    // Idle ones followed by a flag opens a frame.
    push_ones(0, 16);
    drain();
    chk("idle_before_flag", Idle[0], 1);
    push_flag(0);
    drain();
    chk("in_frame_after_flag", InFrame[0], 1);
    read_cnt(0, 3, v);
    chk("flag_count_1", v, 1);

    // A minimum-size good frame with stuffing.
    push_byte(0, 8'hFF); push_byte(0, 8'h01); push_byte(0, 8'h3E); push_byte(0, 8'h7E);
    push_flag(0);
    drain();
    chk("frame_bytes_4", FrameBytes[7:0], 4);
    read_cnt(0, 0, v);
    chk("good_count_1", v, 1);

    // An in-frame abort, followed by a flag that produces no frame event.
    push_byte(0, 8'hA5); push_byte(0, 8'h3C);
    push_raw(0, 8'h7F);
    drain();
    chk("in_frame_after_abort", InFrame[0], 0);
    read_cnt(0, 2, v);
    chk("abort_count_1", v, 1);
    push_flag(0);
    drain();
    read_cnt(0, 1, v);
    chk("no_err_after_hunt_flag", v, 0);

    // A 35-bit frame, then an oversize frame.
    for (int i = 0; i < 35; i++) push_data_bit(0, 1'($urandom));
    push_flag(0);
    drain();
    read_cnt(0, 1, v);
    chk("err_count_35bits", v, 1);
    for (int i = 0; i < 130; i++) push_byte(0, 8'($urandom));
    push_flag(0);
    drain();
    read_cnt(0, 1, v);
    chk("err_count_130bytes", v, 2);

    // A clear on the same edge as a good frame drops that increment.
    for (int i = 0; i < MIN_B; i++) push_byte(0, 8'($urandom));
    push_flag(0);
    guard = 0;
    while (txq[0].size() > 1 && guard < LIMIT) begin
      run_cycle(1'b1);
      guard++;
    end
    RdChan = 2'd0; RdSel = 2'd0; Clr = 1'b1;
    run_cycle(1'b1);
    Clr = 1'b0;
    chk("clr_edge_frame_ok", FrameOk[0], 1);
    chk("clr_wins_rd", RdData, 0);
    read_cnt(0, 3, v);
    chk("clr_flag_count", v, 0);

    // An out-of-range channel reads as zero, and its clear is ignored.
    push_flag(0);
    drain();
    RdChan = 2'd3; RdSel = 2'd3; Clr = 1'b1;
    run_cycle(1'b0);
    Clr = 1'b0;
    chk("bad_chan_rd", RdData, 0);
    read_cnt(0, 3, v);
    chk("bad_chan_clr_ignored", v, 1);

    // A reset in the middle of frames on every channel.
    for (int c = 0; c < CH; c++) begin
      push_flag(c);
      for (int i = 0; i < 3; i++) push_byte(c, 8'($urandom));
    end
    repeat (20) run_cycle(1'b1);
    reset_now();
    read_cnt(0, 3, v);
    chk("post_reset_flag_count", v, 0);

    // Randomized traffic with staggered strobes on all channels.
    en_pct[0] = 55; en_pct[1] = 75; en_pct[2] = 95;
    for (int n = 0; n < 15000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (txq[c].size() == 0) gen_random(c);
      end
      RdChan = 2'($urandom_range(0, 3));
      RdSel  = 2'($urandom_range(0, 3));
      Clr    = ($urandom_range(0, 2999) == 0);
      run_cycle(1'b1);
    end
    Clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
